// File: rtl/cex_stimulus_player_if.sv
// Bundles the trace-load channel, run control and stimulus/status outputs of
// the counterexample stimulus player. The bench drives through "master"; the
// player itself attaches through "slave".
interface cex_stimulus_player_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          load_valid;
  logic          load_bit;
  logic          load_ready;
  logic          clear;
  logic          start;
  logic          mode_random;
  logic          stop;
  logic          A;
  logic          a_valid;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [16:0]   play_count;
  logic [LW-1:0] trace_len;

  modport master (
    output load_valid, load_bit, clear, start, mode_random, stop,
    input  load_ready, A, a_valid, busy, done, timeout, play_count, trace_len
  );

  modport slave (
    input  load_valid, load_bit, clear, start, mode_random, stop,
    output load_ready, A, a_valid, busy, done, timeout, play_count, trace_len
  );
endinterface

// File: rtl/cex_stimulus_player.sv
// Counterexample stimulus player: replays a serially loaded input trace onto
// the 1-bit primary input A of an FSM under test, optionally continuing with
// LFSR bits until stop or until the driven-bit budget runs out.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | trace may be loaded; waiting for start
// PLAY   | driving stored trace bits, one per clock
// RANDOM | trace exhausted, driving LFSR bits
// DONE   | run finished; trace kept for replay, counters held
module cex_stimulus_player #(
  parameter int          DEPTH      = 16,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          MAX_CYCLES = 100000
) (
  input logic              clock,
  input logic              reset,
  cex_stimulus_player_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          LW       = AW + 1;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [16:0] MAX_CNT  = 17'(MAX_CYCLES);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_RANDOM,
    S_DONE
  } state_t;

  state_t        state;
  logic          mem [DEPTH];
  logic [LW-1:0] trace_len;
  logic [LW-1:0] rd_ptr;
  logic [16:0]   play_count;
  logic [15:0]   lfsr;
  logic          mode_q;
  logic          a_q;
  logic          a_valid_q;
  logic          timeout_q;

  logic          load_ready;
  logic          load_fire;
  logic [LW-1:0] len_eff;
  logic          first_bit;
  logic          lfsr_fb;
  logic [15:0]   lfsr_next;
  logic          budget_hit;

  assign load_ready = (state == S_IDLE) && (trace_len < DEPTH_L);
  assign load_fire  = bus.load_valid && load_ready;
  // A bit loaded in the same cycle as start is part of the trace being played.
  assign len_eff    = trace_len + LW'(load_fire);
  // With an empty buffer, the only possible first bit is the one arriving now.
  assign first_bit  = (trace_len == '0) ? bus.load_bit : mem[0];
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_next  = {lfsr[14:0], lfsr_fb};
  assign budget_hit = (play_count == MAX_CNT);

  // Trace buffer write port; contents need no reset.
  always_ff @(posedge clock) begin
    if (load_fire) begin
      mem[trace_len[AW-1:0]] <= bus.load_bit;
    end
  end

  // Sequencer: load accounting, run control and registered stimulus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      trace_len  <= '0;
      rd_ptr     <= '0;
      play_count <= '0;
      lfsr       <= SEED_EFF;
      mode_q     <= 1'b0;
      a_q        <= 1'b0;
      a_valid_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (bus.clear) begin
      // clear beats start and stop; the LFSR deliberately keeps running state.
      state      <= S_IDLE;
      trace_len  <= '0;
      rd_ptr     <= '0;
      play_count <= '0;
      a_q        <= 1'b0;
      a_valid_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (load_fire) begin
        trace_len <= trace_len + LW'(1);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            mode_q    <= bus.mode_random;
            timeout_q <= 1'b0;
            if (len_eff != '0) begin
              state      <= S_PLAY;
              a_q        <= first_bit;
              a_valid_q  <= 1'b1;
              rd_ptr     <= LW'(1);
              play_count <= 17'd1;
            end else if (bus.mode_random) begin
              state      <= S_RANDOM;
              a_q        <= lfsr[15];
              a_valid_q  <= 1'b1;
              lfsr       <= lfsr_next;
              rd_ptr     <= '0;
              play_count <= 17'd1;
            end else begin
              state      <= S_DONE;
              a_q        <= 1'b0;
              a_valid_q  <= 1'b0;
              rd_ptr     <= '0;
              play_count <= '0;
            end
          end
        end
        S_PLAY: begin
          if (bus.stop) begin
            state     <= S_DONE;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
          end else if (budget_hit) begin
            state     <= S_DONE;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
            timeout_q <= 1'b1;
          end else if (rd_ptr == trace_len) begin
            if (mode_q) begin
              // Seamless hand-over: first LFSR bit follows the last trace bit.
              state      <= S_RANDOM;
              a_q        <= lfsr[15];
              lfsr       <= lfsr_next;
              play_count <= play_count + 17'd1;
            end else begin
              state     <= S_DONE;
              a_q       <= 1'b0;
              a_valid_q <= 1'b0;
            end
          end else begin
            a_q        <= mem[rd_ptr[AW-1:0]];
            rd_ptr     <= rd_ptr + LW'(1);
            play_count <= play_count + 17'd1;
          end
        end
        S_RANDOM: begin
          if (bus.stop) begin
            state     <= S_DONE;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
          end else if (budget_hit) begin
            state     <= S_DONE;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            a_q        <= lfsr[15];
            lfsr       <= lfsr_next;
            play_count <= play_count + 17'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          a_q       <= 1'b0;
          a_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.A          = a_q;
  assign bus.a_valid    = a_valid_q;
  assign bus.busy       = (state == S_PLAY) || (state == S_RANDOM);
  assign bus.done       = (state == S_DONE);
  assign bus.timeout    = timeout_q;
  assign bus.play_count = play_count;
  assign bus.trace_len  = trace_len;

endmodule
